add_sub_round_pack_unit: RTL and testbench

Final stage of the FPU add/sub datapath. It takes the normalized sign, exponent and guard-extended mantissa from the normalize stage, plus the special-case selects from the special-case detector. It rounds to nearest-even, detects overflow, flushes underflow to zero, overrides with Inf/NaN when required, and packs an IEEE-754 binary32 result. The stage is a 2-deep elastic pipeline with valid/ready on both sides, sitting between the normalizer and the FFT butterfly result registers.

---
 rtl/fpu_add_sub_pkg.sv | 54 +++++
 rtl/fpu_round_rne.sv | 30 +++
 rtl/add_sub_round_pack_unit.sv | 85 ++++++++
 tb/tb_add_sub_round_pack_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_add_sub_pkg.sv
// Shared binary32 constants, special-select encoding and the S2 classify/pack
// helper for the add/sub round-and-pack stage.
package fpu_add_sub_pkg;

    localparam int unsigned FP32_EXP_W = 8;
    localparam int unsigned FP32_MAN_W = 23;
    localparam logic [FP32_EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // 2'b01 is not a member; any value with bit 1 clear selects the normal path.
    typedef enum logic [1:0] {
        SEL_NORM = 2'b00,
        SEL_INF  = 2'b10,
        SEL_NAN  = 2'b11
    } sel_man_e;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        sel_exp;
        logic [1:0]  sel_man;
        logic [9:0]  exp1;
        logic [23:0] man;
        logic        inexact;
    } s1_t;

    typedef struct packed {
        logic [31:0] result;
        logic        overflow;
        logic        inexact;
    } pack_t;

    function automatic pack_t pack_result(input s1_t s);
        pack_t p;
        p = '0;
        if (s.sel_man == SEL_NAN) begin
            p.result = QNAN;
        end else if (s.sel_man == SEL_INF) begin
            p.result = {s.sel_exp, EXP_MAX, {FP32_MAN_W{1'b0}}};
        end else if (s.zero || (s.exp1 == '0)) begin
            p.result  = {s.sign, 31'h0};
            p.inexact = s.inexact;
        end else if (s.exp1 >= 10'd255) begin
            p.result   = {s.sign, EXP_MAX, {FP32_MAN_W{1'b0}}};
            p.overflow = 1'b1;
            p.inexact  = 1'b1;
        end else begin
            p.result  = {s.sign, s.exp1[FP32_EXP_W-1:0], s.man[FP32_MAN_W-1:0]};
            p.inexact = s.inexact;
        end
        return p;
    endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// Combinational round-to-nearest-even of a guard-extended mantissa, with
// exponent bump on mantissa carry-out.
module fpu_round_rne
    import fpu_add_sub_pkg::*;
(
    input  logic [26:0] man,
    input  logic [8:0]  exp,
    output logic [23:0] man_rnd,
    output logic [9:0]  exp1,
    output logic        inexact
);

    logic        inc;
    logic [24:0] m25;

    assign inc     = man[2] & (man[1] | man[0] | man[3]);
    assign m25     = {1'b0, man[26:3]} + {24'h0, inc};
    assign inexact = |man[2:0];

    always_comb begin
        if (m25[24]) begin
            exp1    = {1'b0, exp} + 10'd1;
            man_rnd = m25[24:1];
        end else begin
            exp1    = {1'b0, exp};
            man_rnd = m25[23:0];
        end
    end

endmodule

// File: rtl/add_sub_round_pack_unit.sv
// Final add/sub stage: round (S1) then classify and pack (S2) in a 2-deep
// elastic valid/ready pipeline producing a binary32 result.
module add_sub_round_pack_unit
    import fpu_add_sub_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign,
    input  logic [8:0]  i_exp,
    input  logic [26:0] i_man,
    input  logic        i_zero,
    input  logic        i_sel_exp,
    input  logic [1:0]  i_sel_man,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_overflow,
    output logic        o_inexact
);

    logic        s1_full;
    logic        s2_full;
    logic        s1_en;
    logic        s2_en;
    s1_t         s1_d;
    s1_t         s1_q;
    pack_t       s2_q;
    logic [23:0] rnd_man;
    logic [9:0]  rnd_exp1;
    logic        rnd_inexact;

    fpu_round_rne u_round (
        .man     (i_man),
        .exp     (i_exp),
        .man_rnd (rnd_man),
        .exp1    (rnd_exp1),
        .inexact (rnd_inexact)
    );

    // s1_en equals ~s1_full | ~s2_full | i_ready; i_ready -> o_ready is the only comb path.
    assign s2_en   = ~s2_full | i_ready;
    assign s1_en   = ~s1_full | s2_en;
    assign o_ready = s1_en;

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = i_sign;
        s1_d.zero    = i_zero;
        s1_d.sel_exp = i_sel_exp;
        s1_d.sel_man = i_sel_man;
        s1_d.exp1    = rnd_exp1;
        s1_d.man     = rnd_man;
        s1_d.inexact = rnd_inexact;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_full <= 1'b0;
            s2_full <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            if (s1_en) begin
                s1_full <= i_valid;
                if (i_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_en) begin
                s2_full <= s1_full;
                if (s1_full) begin
                    s2_q <= pack_result(s1_q);
                end
            end
        end
    end

    assign o_valid    = s2_full;
    assign o_result   = s2_q.result;
    assign o_overflow = s2_q.overflow;
    assign o_inexact  = s2_q.inexact;

endmodule

// File: tb/tb_add_sub_round_pack_unit.sv
// Scoreboard bench for add_sub_round_pack_unit: directed corner cases,
// backpressure, mid-stream reset and a randomized stream against a reference model.
module tb_add_sub_round_pack_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [8:0]  i_exp;
    logic [26:0] i_man;
    logic        i_zero;
    logic        i_sel_exp;
    logic [1:0]  i_sel_man;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_overflow;
    logic        o_inexact;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        inx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic dir_en = 1'b0;
    exp_t dir_val = '0;
    logic rand_ready = 1'b0;
    logic stall_q = 1'b0;
    logic [33:0] stall_v = '0;
    exp_t mon_e;

    add_sub_round_pack_unit dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_sign     (i_sign),
        .i_exp      (i_exp),
        .i_man      (i_man),
        .i_zero     (i_zero),
        .i_sel_exp  (i_sel_exp),
        .i_sel_man  (i_sel_man),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_overflow (o_overflow),
        .o_inexact  (o_inexact)
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t mk(input logic [31:0] r, input logic o, input logic x);
        exp_t t;
        t.res = r;
        t.ovf = o;
        t.inx = x;
        return t;
    endfunction

    // Reference: value/remainder arithmetic on the guard-extended mantissa.
    function automatic exp_t model(input logic s, input logic [8:0] e9, input logic [26:0] m,
                                   input logic z, input logic se, input logic [1:0] sm);
        int unsigned q;
        int unsigned rem;
        int          e;
        logic        inx;
        logic [31:0] qv;
        logic [31:0] ev;
        if (sm == 2'b11) return mk(32'h7FC00000, 1'b0, 1'b0);
        if (sm == 2'b10) return mk({se, 8'hFF, 23'h0}, 1'b0, 1'b0);
        q   = int'(m) / 8;
        rem = int'(m) % 8;
        inx = (rem != 0);
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        e = int'(e9);
        if (q >= (1 << 24)) begin
            q = q / 2;
            e = e + 1;
        end
        if (z || e == 0) return mk({s, 31'h0}, 1'b0, inx);
        if (e >= 255) return mk({s, 8'hFF, 23'h0}, 1'b1, 1'b1);
        qv = q;
        ev = e;
        return mk({s, ev[7:0], qv[22:0]}, 1'b0, inx);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: pops on output transfer, checks hold-while-stalled, pushes on input transfer.
    always @(negedge i_clk) begin
        if (i_rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 32'(o_valid), 32'd1);
                check("hold_result", o_result, stall_v[33:2]);
                check("hold_flags", 32'({o_overflow, o_inexact}), 32'(stall_v[1:0]));
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got %h want none", o_result);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", o_result, mon_e.res);
                    check("overflow", 32'(o_overflow), 32'(mon_e.ovf));
                    check("inexact", 32'(o_inexact), 32'(mon_e.inx));
                end
            end
            stall_q = o_valid && !i_ready;
            stall_v = {o_result, o_overflow, o_inexact};
            if (i_valid && o_ready)
                sb.push_back(dir_en ? dir_val :
                             model(i_sign, i_exp, i_man, i_zero, i_sel_exp, i_sel_man));
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
        if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send(input logic s, input logic [8:0] e, input logic [26:0] m, input logic z,
                        input logic se, input logic [1:0] sm, input logic de, input exp_t dv);
        logic acc;
        i_sign = s; i_exp = e; i_man = m; i_zero = z; i_sel_exp = se; i_sel_man = sm;
        dir_en = de; dir_val = dv;
        i_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge i_clk);
            acc = o_ready;
            step();
            if (acc) begin
                i_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout got o_ready=0 want 1");
        i_valid = 1'b0;
    endtask

    task automatic send_m(input logic s, input logic [8:0] e, input logic [26:0] m, input logic z,
                          input logic se, input logic [1:0] sm);
        send(s, e, m, z, se, sm, 1'b0, '0);
    endtask

    task automatic send_d(input logic s, input logic [8:0] e, input logic [26:0] m, input logic z,
                          input logic se, input logic [1:0] sm, input exp_t dv);
        send(s, e, m, z, se, sm, 1'b1, dv);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [8:0]  re;
        logic [26:0] rm;
        logic [1:0]  rs;
        int          r;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_sign = 1'b0; i_exp = '0; i_man = '0; i_zero = 1'b0; i_sel_exp = 1'b0; i_sel_man = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'h0);
        check("rst_flags", 32'({o_overflow, o_inexact}), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);

        // Basic pass with latency check.
        send_d(1'b0, 9'd127, 27'h4000000, 1'b0, 1'b0, 2'b00, mk(32'h3F800000, 1'b0, 1'b0));
        check("lat_early", 32'(o_valid), 32'd0);
        @(posedge i_clk);
        #1;
        check("lat_valid", 32'(o_valid), 32'd1);
        check("lat_result", o_result, 32'h3F800000);

        send_d(1'b0, 9'd127, 27'h400000C, 1'b0, 1'b0, 2'b00, mk(32'h3F800002, 1'b0, 1'b1));
        send_d(1'b0, 9'd127, 27'h4000004, 1'b0, 1'b0, 2'b00, mk(32'h3F800000, 1'b0, 1'b1));
        send_d(1'b0, 9'd127, 27'h7FFFFFC, 1'b0, 1'b0, 2'b00, mk(32'h40000000, 1'b0, 1'b1));
        send_d(1'b0, 9'd254, 27'h7FFFFFC, 1'b0, 1'b0, 2'b00, mk(32'h7F800000, 1'b1, 1'b1));
        send_d(1'b1, 9'd200, 27'h5A5A5A7, 1'b1, 1'b1, 2'b11, mk(32'h7FC00000, 1'b0, 1'b0));
        send_d(1'b0, 9'h1FF, 27'h7FFFFFF, 1'b0, 1'b1, 2'b10, mk(32'hFF800000, 1'b0, 1'b0));
        send_d(1'b1, 9'd100, 27'h4000003, 1'b1, 1'b0, 2'b00, mk(32'h80000000, 1'b0, 1'b1));
        send_d(1'b0, 9'd0,   27'h4000000, 1'b0, 1'b0, 2'b00, mk(32'h00000000, 1'b0, 1'b0));
        send_d(1'b0, 9'd0,   27'h7FFFFFC, 1'b0, 1'b0, 2'b00, mk(32'h00800000, 1'b0, 1'b1));
        send_d(1'b1, 9'h100, 27'h4000000, 1'b0, 1'b0, 2'b00, mk(32'hFF800000, 1'b1, 1'b1));
        send_d(1'b0, 9'd254, 27'h7FFFFF8, 1'b0, 1'b0, 2'b00, mk(32'h7F7FFFFF, 1'b0, 1'b0));
        send_d(1'b0, 9'd130, 27'h4000001, 1'b0, 1'b0, 2'b01, mk(32'h41000000, 1'b0, 1'b1));
        idle(4);

        // Backpressure: four inputs, i_ready low for three cycles.
        i_ready = 1'b0;
        fork
            begin
                send_m(1'b0, 9'd10, 27'h4000010, 1'b0, 1'b0, 2'b00);
                send_m(1'b1, 9'd20, 27'h4100020, 1'b0, 1'b0, 2'b00);
                send_m(1'b0, 9'd30, 27'h4200034, 1'b0, 1'b0, 2'b00);
                send_m(1'b1, 9'd40, 27'h4300047, 1'b0, 1'b0, 2'b00);
            end
            begin
                repeat (2) @(posedge i_clk);
                #1;
                check("bp_ready_low", 32'(o_ready), 32'd0);
                check("bp_valid", 32'(o_valid), 32'd1);
                @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
        join
        idle(6);

        // Reset with both stages full.
        i_ready = 1'b0;
        send_m(1'b0, 9'd50, 27'h4000000, 1'b0, 1'b0, 2'b00);
        send_m(1'b0, 9'd60, 27'h4000000, 1'b0, 1'b0, 2'b00);
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        check("pre_rst_ready", 32'(o_ready), 32'd0);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_result", o_result, 32'h0);
        check("async_rst_flags", 32'({o_overflow, o_inexact}), 32'd0);
        sb.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("post_rst_ready", 32'(o_ready), 32'd1);
        send_d(1'b1, 9'd127, 27'h400000C, 1'b0, 1'b0, 2'b00, mk(32'hBF800002, 1'b0, 1'b1));
        @(posedge i_clk);
        #1;
        check("post_rst_valid", 32'(o_valid), 32'd1);
        check("post_rst_result", o_result, 32'hBF800002);
        idle(3);

        // Randomized stream with random downstream backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            r = $urandom_range(0, 9);
            case (r)
                0: re = 9'd0;
                1: re = 9'd254;
                2: re = 9'd255;
                3: re = 9'h100 + 9'($urandom_range(0, 255));
                4: re = 9'd1;
                default: re = 9'($urandom_range(1, 253));
            endcase
            rm = {1'b1, 26'($urandom)};
            if ($urandom_range(0, 4) == 0) rm[2:0] = 3'b100;
            if ($urandom_range(0, 7) == 0) rm[26:3] = 24'hFFFFFF;
            r = $urandom_range(0, 15);
            rs = (r == 0) ? 2'b11 : (r == 1) ? 2'b10 : (r == 2) ? 2'b01 : 2'b00;
            send_m(1'($urandom), re, rm, ($urandom_range(0, 15) == 0), 1'($urandom), rs);
        end
        rand_ready = 1'b0;
        i_ready = 1'b1;
        i_valid = 1'b0;
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge i_clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
